// File: rtl/led_frame_sched_pkg.sv
// Shared types and helpers for the LED frame scheduler.
// Builds the per-LED 32-bit word that the serial PHY transmits.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ISSUE,
    GUARD
  } sched_state_t;

  localparam logic [2:0] LED_HDR = 3'b111;

  function automatic logic [31:0] pack_led(input logic [4:0] bright,
                                           input logic [7:0] b,
                                           input logic [7:0] g,
                                           input logic [7:0] r);
    return {LED_HDR, bright, b, g, r};
  endfunction

endpackage

// File: rtl/led_frame_sched_if.sv
// Writer-side bus of the scheduler: host register port plus animation frame port.
// The master drives requests and data, and the slave (the scheduler) returns the grants.
interface led_frame_sched_if #(
  parameter int unsigned LED_NUM = 4
) ();
  import led_pkg::*;

  localparam int unsigned IDX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;

  logic                   host_req;
  logic [IDX_W-1:0]       host_idx;
  logic [23:0]            host_color;
  logic [4:0]             host_bright;
  logic                   host_ack;

  logic                   anim_valid;
  logic [LED_NUM*24-1:0]  anim_frame;
  logic                   anim_ready;
  logic [4:0]             global_bright;

  modport master (
    output host_req, host_idx, host_color, host_bright,
    output anim_valid, anim_frame, global_bright,
    input  host_ack, anim_ready
  );

  modport slave (
    input  host_req, host_idx, host_color, host_bright,
    input  anim_valid, anim_frame, global_bright,
    output host_ack, anim_ready
  );

endinterface

// File: rtl/led_frame_sched_arb.sv
// Two-requester round-robin arbiter; req[0] is host, req[1] is anim.
// The pointer moves only on contested cycles, so a lone grant does not change who wins the next tie.
module led_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (en && (req == 2'b11)) begin
      last_d = gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/led_frame_sched.sv
// Frame scheduler in front of the LED serial PHY: shared colour buffer,
// refresh/force triggered sends and a guard interval between PHY strobes.
module led_frame_sched
  import led_pkg::*;
#(
  parameter int unsigned LED_NUM     = 4,
  parameter int unsigned REFRESH_CNT = 150000,
  parameter int unsigned GUARD_CNT   = 2200
) (
  input  logic                  clk,
  input  logic                  rst,
  led_frame_sched_if.slave      bus,
  input  logic                  force_refresh,
  output logic                  phy_enable,
  output logic [LED_NUM*32-1:0] phy_data,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);

  localparam int unsigned IDX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam int unsigned TMR_W = $clog2(REFRESH_CNT + 1);
  localparam int unsigned GRD_W = $clog2(GUARD_CNT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CNT - 1);
  localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_CNT - 1);

  sched_state_t          state_q, state_d;
  logic                  busy_q;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  refresh_pend_q, refresh_pend_d;
  logic                  force_pend_q, force_pend_d;
  logic                  dirty_q, dirty_d;
  logic [GRD_W-1:0]      guard_q, guard_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [LED_NUM*32-1:0] phy_data_q, phy_data_d;
  logic [23:0]           color_q  [LED_NUM];
  logic [4:0]            bright_q [LED_NUM];

  logic       wr_en, idx_ok, host_hit, anim_hit, refresh_tick, refresh_now, force_now;
  logic [1:0] gnt;

  assign wr_en = !rst && (state_q != ARM);

  led_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.anim_valid, bus.host_req}),
    .en  (wr_en),
    .gnt (gnt)
  );

  assign bus.host_ack   = gnt[0];
  assign bus.anim_ready = gnt[1];

  if ((2 ** IDX_W) != LED_NUM) begin : g_idx_chk
    assign idx_ok = (32'(bus.host_idx) < LED_NUM);
  end else begin : g_idx_all
    assign idx_ok = 1'b1;
  end

  assign host_hit     = gnt[0] && idx_ok;
  assign anim_hit     = gnt[1];
  assign refresh_tick = (tmr_q == TMR_LAST);
  assign refresh_now  = refresh_pend_q || refresh_tick;
  assign force_now    = force_pend_q || force_refresh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if ((refresh_now && dirty_q) || force_now) state_d = ARM;
      ARM:     state_d = ISSUE;
      ISSUE:   state_d = GUARD;
      GUARD:   if (guard_q == GRD_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Guard count starts at 0 in the ISSUE cycle, so strobes are GUARD_CNT+2 apart.
  always_comb begin
    phy_enable  = (state_q == ISSUE);
    frame_cnt_d = (state_q == ISSUE) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    guard_d     = guard_q;
    phy_data_d  = phy_data_q;
    if (state_q == ARM) begin
      guard_d = '0;
      for (int unsigned i = 0; i < LED_NUM; i++) begin
        phy_data_d[(LED_NUM-1-i)*32 +: 32] = pack_led(bright_q[i], color_q[i][23:16],
                                                      color_q[i][15:8], color_q[i][7:0]);
      end
    end else if ((state_q == ISSUE) || (state_q == GUARD)) begin
      guard_d = guard_q + 1'b1;
    end
  end

  // A set arriving in the ARM cycle outlives the clear and triggers the next send.
  always_comb begin
    tmr_d          = refresh_tick ? '0 : tmr_q + 1'b1;
    refresh_pend_d = (refresh_pend_q && (state_q != ARM)) || refresh_tick;
    force_pend_d   = (force_pend_q && (state_q != ARM)) || force_refresh;
    dirty_d        = (dirty_q && (state_q != ARM)) || host_hit || anim_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q         <= 1'b0;
      tmr_q          <= '0;
      refresh_pend_q <= 1'b0;
      force_pend_q   <= 1'b0;
      dirty_q        <= 1'b1;
      guard_q        <= '0;
      frame_cnt_q    <= '0;
      phy_data_q     <= '0;
    end else begin
      busy_q         <= (state_d != IDLE);
      tmr_q          <= tmr_d;
      refresh_pend_q <= refresh_pend_d;
      force_pend_q   <= force_pend_d;
      dirty_q        <= dirty_d;
      guard_q        <= guard_d;
      frame_cnt_q    <= frame_cnt_d;
      phy_data_q     <= phy_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LED_NUM; i++) begin
        color_q[i]  <= '0;
        bright_q[i] <= '0;
      end
    end else if (anim_hit) begin
      for (int unsigned i = 0; i < LED_NUM; i++) begin
        color_q[i]  <= bus.anim_frame[(LED_NUM-1-i)*24 +: 24];
        bright_q[i] <= bus.global_bright;
      end
    end else if (host_hit) begin
      color_q[bus.host_idx]  <= bus.host_color;
      bright_q[bus.host_idx] <= bus.host_bright;
    end
  end

  assign phy_data  = phy_data_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/led_frame_sched.md
# led_frame_sched

Frame scheduler sitting in front of the LED serial PHY (the 150 MHz APA102-style sender that takes a one-cycle `enable` plus a `LED_NUM*32`-bit frame and serialises start/LED/end frames). It owns a per-LED colour/brightness buffer and shares it between two writers: a host register port and an animation source, using round-robin arbitration. It issues PHY transmissions on a periodic refresh tick or a forced request, and holds off the next transmission for a guard interval, because the PHY exposes no busy flag.

## Interface
- `LED_NUM`, 4: LEDs per frame. The PHY requires 4, so `phy_data` is 128 bits.
- `REFRESH_CNT`, 150000: clk cycles per refresh tick (1 kHz at 150 MHz).
- `GUARD_CNT`, 2200: clk cycles after `phy_enable` before another issue is allowed. Must be ≥ the PHY's full-frame time.
- `clk` in 1: 150 MHz system clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `host_req` in 1: host write request. Held high until `host_ack`.
- `host_idx` in $clog2(LED_NUM): LED index to write.
- `host_color` in 24: {B,G,R}.
- `host_bright` in 5: brightness for that LED.
- `host_ack` out 1: write accepted this cycle.
- `anim_valid` in 1: a whole animation frame is offered.
- `anim_frame` in LED_NUM*24: LED0 is at the MSBs, {B,G,R} per LED.
- `anim_ready` out 1: frame accepted this cycle (valid&ready handshake).
- `global_bright` in 5: brightness applied to every LED on an anim write.
- `force_refresh` in 1: one-cycle pulse requesting an immediate send.
- `phy_enable` out 1: one-cycle send strobe to the PHY.
- `phy_data` out LED_NUM*32: packed frame, stable while `phy_enable`=1.
- `busy` out 1: high whenever state ≠ IDLE.
- `frame_cnt` out 16: number of frames issued. Wraps 0xFFFF→0.

## Operation
- **States.**
  - IDLE: if (`refresh_pend`&&`dirty`) || `force_pend`, go to ARM; otherwise stay.
  - ARM (1 cycle): `phy_data` ← pack(buffer); clear `refresh_pend`, `force_pend`, `dirty`; go to ISSUE.
  - ISSUE (1 cycle): `phy_enable`=1; `frame_cnt`++; `guard_cnt`←0; go to GUARD.
  - GUARD: `guard_cnt` counts up. At `GUARD_CNT-1`, go to IDLE.
- **LED word packing.** For LED i: {3'b111, bright[i], B, G, R}. LED0 occupies `phy_data[LED_NUM*32-1 -: 32]` and is transmitted first.
- **Write acceptance.** At most one write per cycle. Writes are accepted in IDLE, ISSUE and GUARD, never in ARM, so the snapshot is atomic. `host_ack`/`anim_ready` are combinational grants and are 0 in ARM and during `rst`.
- **Host write.** Sets color[idx] and bright[idx], and sets `dirty`. An index ≥ LED_NUM is acked but ignored, and `dirty` is not set.
- **Anim write.** Updates all colours, sets every bright to `global_bright`, and sets `dirty`.
- **Arbitration.** Two-way round-robin. When both request, the grant goes to the requester not granted last. With a single requester, that requester is granted. The last-grant pointer resets to anim, so host wins the first tie.
- **Refresh timer.** Free-running 0..`REFRESH_CNT-1`. The terminal count sets `refresh_pend`. The timer is never stalled by the FSM.
- **force_refresh.** Sets `force_pend`. A pulse arriving while busy is remembered, and the send happens after GUARD.
- **Set/clear priority.** If set and clear of `refresh_pend`/`force_pend` coincide (the ARM cycle), set wins, so the pending request survives to the next issue.
- **Reset values.**
  - Outputs: `phy_enable`=0, `phy_data`=0, `host_ack`=0, `anim_ready`=0, `busy`=0, `frame_cnt`=0.
  - Internal: buffer all zero, `dirty`=1, pends 0, timer 0.
  - `rst` asserted mid-GUARD aborts to IDLE on the next edge. The PHY is not notified.

## Timing
- Latency from the IDLE decision to `phy_enable`: 2 clk (ARM, then ISSUE).
- `phy_data` is registered in ARM and holds until the next ARM.
- Minimum spacing between `phy_enable` pulses: `GUARD_CNT`+2 cycles.
- A write accepted in cycle t is visible in the next ARM at ≥ t+1.
- A write in the ISSUE cycle does not affect the frame in flight; it sets `dirty` for the next frame.
- `busy` is a registered decode of the state: it rises in the cycle ARM is entered.

## Structure
- Package `led_pkg`:
  - `sched_state_t` enum {IDLE, ARM, ISSUE, GUARD}.
  - `LED_HDR`=3'b111.
  - function `pack_led(bright, b, g, r)` returning 32 bits.
- Sub-module `led_rr_arb2`: a 2-requester round-robin arbiter with `req[1:0]`, `en`, `gnt[1:0]` and a registered last-grant pointer.

## Test plan
Bench parameters: `REFRESH_CNT`=100, `GUARD_CNT`=50.
- **Reset only.** First tick at cycle 99 → `phy_enable` at cycle 101. `phy_data`=0xE0000000 repeated ×4. `frame_cnt`=1.
- **Host write, no redundant send.** idx 2, color 0x0000FF, bright 0x1F → next frame word 2 = 0xFF0000FF. With no further writes, later ticks issue nothing.
- **Tie, then lone requester.** `host_req` and `anim_valid` asserted together, both held → host acked first, anim accepted the next cycle. Next tie → anim first.
- **Writes in ARM.** `anim_valid` held during ARM → `anim_ready`=0 in ARM, accepted in ISSUE. That frame's `phy_data` is the old buffer; the following frame carries the anim data.
- **force_refresh during GUARD.** → second `phy_enable` exactly 52 cycles after the first, even with `dirty`=0.
- **Counter wrap and mid-GUARD reset.** Preload 0xFFFF issues → `frame_cnt` wraps to 0. `rst` pulse in GUARD → IDLE and all outputs at reset values next cycle.
